branch_resolve_unit: RTL and testbench

// - Parametrised, registered branch-condition resolver for the MIPS pipeline.
// - Sits between ID/EX operand forwarding and PC-select/flush logic.
// - Evaluates the condition for 10 branch ops, compares the outcome with the fetch-stage

---
 rtl/branch_resolve_unit.sv | 121 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch-condition resolver with a 1-deep
// valid/ready output stage. It evaluates the branch condition, flags a
// mispredict against the fetch prediction and flags unknown opcodes.
// Optional feature macro: BRU_STATS_EN enables saturating retire and
// mispredict counters. When the macro is undefined, both counters read 0.
module branch_resolve_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             br_taken,
   output logic             mispredict,
   output logic             op_err,
   output logic [CNT_W-1:0] stat_br,
   output logic [CNT_W-1:0] stat_mis
);

   logic r_out_valid;
   logic r_br_taken;
   logic r_mispredict;
   logic r_op_err;

   logic w_eq;
   logic w_a_neg;
   logic w_a_zero;
   logic w_lts;
   logic w_ltu;
   logic w_taken;
   logic w_err;
   logic w_accept;
   logic w_retire;

   assign w_eq     = (a == b);
   assign w_a_neg  = a[WIDTH-1];
   assign w_a_zero = (a == '0);
   assign w_lts    = ($signed(a) < $signed(b));
   assign w_ltu    = (a < b);

   // Condition evaluation; unknown opcodes resolve not-taken and raise op_err.
   always_comb begin
      w_taken = 1'b0;
      w_err   = 1'b0;
      case (op)
         4'b0000: w_taken = w_eq;
         4'b0100: w_taken = !w_eq;
         4'b0101: w_taken = w_a_neg || w_a_zero;
         4'b0110: w_taken = !w_a_neg && !w_a_zero;
         4'b0111: w_taken = w_a_neg;
         4'b1000: w_taken = !w_a_neg;
         4'b1001: w_taken = w_lts;
         4'b1010: w_taken = !w_lts;
         4'b1011: w_taken = w_ltu;
         4'b1100: w_taken = !w_ltu;
         default: w_err   = 1'b1;
      endcase
   end

   // The stage can take a new op when it is empty or is being drained this cycle.
   assign in_ready = !flush && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_retire = r_out_valid && out_ready && !flush;

   // EMPTY/FULL occupancy. Flush takes priority over accept and retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_out_valid <= 1'b0;
      else if (flush)    r_out_valid <= 1'b0;
      else if (w_accept) r_out_valid <= 1'b1;
      else if (w_retire) r_out_valid <= 1'b0;
   end

   // Result data loads only on accept, so it holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_taken   <= 1'b0;
         r_mispredict <= 1'b0;
         r_op_err     <= 1'b0;
      end else if (w_accept) begin
         r_br_taken   <= w_taken;
         r_mispredict <= w_taken ^ pred_taken;
         r_op_err     <= w_err;
      end
   end

   assign out_valid  = r_out_valid;
   assign br_taken   = r_br_taken;
   assign mispredict = r_mispredict;
   assign op_err     = r_op_err;

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] r_stat_br;
   logic [CNT_W-1:0] r_stat_mis;

   // Saturating retire counters. The mispredict count uses the retiring result's flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else if (w_retire) begin
         if (r_stat_br != '1)                  r_stat_br  <= r_stat_br + 1'b1;
         if (r_mispredict && r_stat_mis != '1) r_stat_mis <= r_stat_mis + 1'b1;
      end
   end

   assign stat_br  = r_stat_br;
   assign stat_mis = r_stat_mis;
`else
   assign stat_br  = '0;
   assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: table vectors, handshake corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_branch_resolve_unit;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
`ifdef BRU_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int CMAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       op = 4'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             pred_taken = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             br_taken;
   logic             mispredict;
   logic             op_err;
   logic [CNT_W-1:0] stat_br;
   logic [CNT_W-1:0] stat_mis;

   branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .pred_taken(pred_taken), .out_valid(out_valid),
      .out_ready(out_ready), .br_taken(br_taken), .mispredict(mispredict), .op_err(op_err),
      .stat_br(stat_br), .stat_mis(stat_mis)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a single pending result plus two retire counts.
   bit m_valid, m_taken, m_mis, m_err;
   int m_br, m_mc;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_br(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output bit t, output bit e);
      longint sx, sy, ux, uy;
      sx = $signed(x); sy = $signed(y); ux = x; uy = y;
      e = 1'b0; t = 1'b0;
      case (o)
         4'd0:  t = (sx == sy);
         4'd4:  t = (sx != sy);
         4'd5:  t = (sx <= 0);
         4'd6:  t = (sx > 0);
         4'd7:  t = (sx < 0);
         4'd8:  t = (sx >= 0);
         4'd9:  t = (sx < sy);
         4'd10: t = (sx >= sy);
         4'd11: t = (ux < uy);
         4'd12: t = (ux >= uy);
         default: e = 1'b1;
      endcase
   endfunction

   function automatic bit exp_ready();
      return !flush && (!m_valid || out_ready);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_taken = 0; m_mis = 0; m_err = 0; m_br = 0; m_mc = 0;
   endtask

   task automatic model_edge();
      bit rdy, acc, ret, t, e;
      rdy = exp_ready();
      acc = in_valid && rdy;
      ret = m_valid && out_ready && !flush;
      if (ret && STATS) begin
         if (m_br < CMAX) m_br++;
         if (m_mis && m_mc < CMAX) m_mc++;
      end
      if (flush) m_valid = 0;
      else if (acc) begin
         ref_br(op, a, b, t, e);
         m_valid = 1; m_taken = t; m_mis = t ^ pred_taken; m_err = e;
      end else if (ret) m_valid = 0;
   endtask

   task automatic check_out();
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("br_taken", br_taken, m_taken);
         chk("mispredict", mispredict, m_mis);
         chk("op_err", op_err, m_err);
      end
      chk("stat_br", stat_br, m_br);
      chk("stat_mis", stat_mis, m_mc);
   endtask

   // One cycle: inputs already driven at a falling edge; check in_ready, clock, check outputs.
   task automatic step();
      #1 chk("in_ready", in_ready, exp_ready());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_out();
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        pred;
      logic        t, m, e;
   } vec_t;
   vec_t vt[14];

   bit ht, he;
   logic hold_t, hold_m, hold_e;

   initial begin
      vt[0]  = '{4'b0000, 32'd5,          32'd5, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{4'b1001, 32'hFFFF_FFFF,  32'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{4'b1011, 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{4'b0101, 32'hFFFF_FFFF,  32'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{4'b1111, 32'd7,          32'd7, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[6]  = '{4'b0101, 32'd0,          32'd9, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[7]  = '{4'b0110, 32'd0,          32'd9, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{4'b1000, 32'h8000_0000,  32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{4'b0110, 32'd1,          32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[10] = '{4'b0010, 32'd1,          32'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[11] = '{4'b1100, 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[12] = '{4'b1010, 32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[13] = '{4'b0100, 32'd3,          32'd4, 1'b1, 1'b1, 1'b0, 1'b0};

      model_reset();
      // Reset state
      #12;
      chk("rst out_valid", out_valid, 0);
      chk("rst br_taken", br_taken, 0);
      chk("rst mispredict", mispredict, 0);
      chk("rst op_err", op_err, 0);
      chk("rst stat_br", stat_br, 0);
      chk("rst stat_mis", stat_mis, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("idle in_ready", in_ready, 1);

      // Table vectors, one per cycle with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b; pred_taken = vt[i].pred;
         step();
         chk($sformatf("vec%0d taken", i), br_taken, vt[i].t);
         chk($sformatf("vec%0d mis", i), mispredict, vt[i].m);
         chk($sformatf("vec%0d err", i), op_err, vt[i].e);
      end

      // Backpressure: stall three cycles with a new op offered, then drain back-to-back
      in_valid = 1'b1; op = 4'b1001; a = 32'd2; b = 32'd3; pred_taken = 1'b0;
      step();
      hold_t = br_taken; hold_m = mispredict; hold_e = op_err;
      out_ready = 1'b0; op = 4'b0000; a = 32'd1; b = 32'd2; pred_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall in_ready", in_ready, 0);
         chk("stall taken hold", br_taken, hold_t);
         chk("stall mis hold", mispredict, hold_m);
         chk("stall err hold", op_err, hold_e);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op = (i % 2) ? 4'b0100 : 4'b0000; a = i; b = 1;
         step();
         ref_br(op, a, b, ht, he);
         chk("b2b out_valid", out_valid, 1);
         chk("b2b taken", br_taken, ht);
      end

      // Flush with both a pending result and an offered input
      in_valid = 1'b1; flush = 1'b1;
      #1 chk("flush in_ready", in_ready, 0);
      step();
      chk("flush out_valid", out_valid, 0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("post-flush empty", out_valid, 0);

      // Repeated mispredicting retires drive the counters into saturation
      in_valid = 1'b1; out_ready = 1'b1; op = 4'b0000; a = 32'd9; b = 32'd9; pred_taken = 1'b0;
      for (int i = 0; i < 21; i++) step();
      chk("sat stat_br", stat_br, STATS ? CMAX : 0);
      chk("sat stat_mis", stat_mis, STATS ? CMAX : 0);

      // Asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst br_taken", br_taken, 0);
      chk("mid rst mispredict", mispredict, 0);
      chk("mid rst op_err", op_err, 0);
      chk("mid rst stat_br", stat_br, 0);
      chk("mid rst stat_mis", stat_mis, 0);
      chk("mid rst in_ready", in_ready, 1);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         op         = 4'($urandom_range(0, 15));
         pred_taken = 1'($urandom);
         case ($urandom_range(0, 5))
            0: a = '0;
            1: a = '1;
            2: a = 32'h8000_0000;
            3: a = 32'h7FFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom : a + 1);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
